// File: rtl/axil_chip_mem_slave_if.sv
// AXI4-Lite bus bundle between a single master and the chip memory slave.
interface axil_chip_mem_slave_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_chip_mem_slave.sv
// AXI4-Lite single-beat word RAM slave with byte strobes.
// Optional macro AXIL_MEM_RANGE_CHECK_EN: SLVERR for addresses >= DEPTH*4.
module axil_chip_mem_slave #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axil_chip_mem_slave_if.slave   s_axil
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write path state
    logic              r_aw_held, w_aw_held_d;
    logic [ADDR_W-1:0] r_aw_addr, w_aw_addr_d;
    logic              r_w_held, w_w_held_d;
    logic [DATA_W-1:0] r_w_data, w_w_data_d;
    logic [STRB_W-1:0] r_w_strb, w_w_strb_d;
    logic              r_bvalid, w_bvalid_d;
    logic [1:0]        r_bresp, w_bresp_d;

    // Read path state
    logic              r_rvalid, w_rvalid_d;
    logic [DATA_W-1:0] r_rdata, w_rdata_d;
    logic [1:0]        r_rresp, w_rresp_d;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_do_write;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [STRB_W-1:0] w_wr_strb;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    logic              w_wr_oor, w_rd_oor;

    // Readies are forced low while reset is asserted.
    assign s_axil.awready = aresetn && !r_aw_held && !r_bvalid;
    assign s_axil.wready  = aresetn && !r_w_held && !r_bvalid;
    assign s_axil.arready = aresetn && !r_rvalid;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;

    assign w_aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_w_hs  = s_axil.wvalid && s_axil.wready;
    assign w_ar_hs = s_axil.arvalid && s_axil.arready;

    // Held values take priority; otherwise use the beat handshaking this cycle.
    assign w_wr_addr  = r_aw_held ? r_aw_addr : s_axil.awaddr;
    assign w_wr_data  = r_w_held ? r_w_data : s_axil.wdata;
    assign w_wr_strb  = r_w_held ? r_w_strb : s_axil.wstrb;
    assign w_do_write = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_idx = w_wr_addr[IDX_W+1:2];
    assign w_rd_idx = s_axil.araddr[IDX_W+1:2];

`ifdef AXIL_MEM_RANGE_CHECK_EN
    assign w_wr_oor = |w_wr_addr[ADDR_W-1:IDX_W+2];
    assign w_rd_oor = |s_axil.araddr[ADDR_W-1:IDX_W+2];
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    logic w_unused;
    assign w_unused = ^{s_axil.awprot, s_axil.arprot, w_wr_addr[1:0], s_axil.araddr[1:0],
                        w_wr_addr[ADDR_W-1:IDX_W+2], s_axil.araddr[ADDR_W-1:IDX_W+2]};

    always_comb begin
        w_aw_held_d = r_aw_held;
        w_aw_addr_d = r_aw_addr;
        w_w_held_d  = r_w_held;
        w_w_data_d  = r_w_data;
        w_w_strb_d  = r_w_strb;
        w_bvalid_d  = r_bvalid;
        w_bresp_d   = r_bresp;

        if (w_aw_hs) begin
            w_aw_held_d = 1'b1;
            w_aw_addr_d = s_axil.awaddr;
        end
        if (w_w_hs) begin
            w_w_held_d = 1'b1;
            w_w_data_d = s_axil.wdata;
            w_w_strb_d = s_axil.wstrb;
        end

        if (w_do_write) begin
            w_aw_held_d = 1'b0;
            w_w_held_d  = 1'b0;
            w_bvalid_d  = 1'b1;
            w_bresp_d   = w_wr_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (r_bvalid && s_axil.bready) begin
            w_bvalid_d = 1'b0;
        end
    end

    always_comb begin
        w_rvalid_d = r_rvalid;
        w_rdata_d  = r_rdata;
        w_rresp_d  = r_rresp;

        if (w_ar_hs) begin
            w_rvalid_d = 1'b1;
            w_rdata_d  = w_rd_oor ? '0 : r_mem[w_rd_idx];
            w_rresp_d  = w_rd_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && s_axil.rready) begin
            w_rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_aw_held <= w_aw_held_d;
            r_aw_addr <= w_aw_addr_d;
            r_w_held  <= w_w_held_d;
            r_w_data  <= w_w_data_d;
            r_w_strb  <= w_w_strb_d;
            r_bvalid  <= w_bvalid_d;
            r_bresp   <= w_bresp_d;
            r_rvalid  <= w_rvalid_d;
            r_rdata   <= w_rdata_d;
            r_rresp   <= w_rresp_d;
        end
    end

    // RAM is not reset; w_do_write is already low during reset since readies are gated.
    always_ff @(posedge aclk) begin
        if (w_do_write && !w_wr_oor) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (w_wr_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axil_chip_mem_slave.sv
// Directed self-checking bench for axil_chip_mem_slave (either range-check build).
module tb_axil_chip_mem_slave;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    axil_chip_mem_slave_if #(.ADDR_W(32)) bus ();

    axil_chip_mem_slave #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (1024)
    ) dut (
        .aclk   (clk),
        .aresetn(rst_n),
        .s_axil (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic aw_p, w_p;
        int   n;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        aw_p = 1'b1;
        w_p  = 1'b1;
        resp = 2'b11;
        n    = 0;
        while ((aw_p || w_p) && n < 20) begin
            if (bus.awvalid && bus.awready) aw_p = 1'b0;
            if (bus.wvalid && bus.wready) w_p = 1'b0;
            tick();
            if (!aw_p) bus.awvalid = 1'b0;
            if (!w_p) bus.wvalid = 1'b0;
            n++;
        end
        if (aw_p || w_p) begin
            check("wr_hs_timeout", 32'd0, 32'd1);
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
        end
        n = 0;
        while (!bus.bvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.bvalid) begin
            check("wr_b_timeout", 32'd0, 32'd1);
        end else begin
            resp = bus.bresp;
            tick();
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int n;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        data = 32'hxxxx_xxxx;
        resp = 2'b11;
        n    = 0;
        while (!bus.arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rvalid) begin
            check("rd_timeout", 32'd0, 32'd1);
        end else begin
            data = bus.rdata;
            resp = bus.rresp;
            tick();
        end
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;

    initial begin
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", bus.awready, 1);
        check("post_rst_arready", bus.arready, 1);

        // Basic write with AW and W together, latency 1 response
        bus.awaddr = 32'h10; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        check("basic_wready", bus.wready, 1);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("basic_bvalid", bus.bvalid, 1);
        check("basic_bresp", bus.bresp, 0);
        check("basic_awready_busy", bus.awready, 0);
        tick();
        check("basic_bvalid_clr", bus.bvalid, 0);
        bus.araddr = 32'h10; bus.arvalid = 1'b1; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("basic_rvalid", bus.rvalid, 1);
        check("basic_rdata", bus.rdata, 32'hDEADBEEF);
        check("basic_rresp", bus.rresp, 0);
        tick();
        check("basic_rvalid_clr", bus.rvalid, 0);

        // Split write: W three cycles ahead of AW
        bus.wdata = 32'h11223344; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("split_wready_drop", bus.wready, 0);
        check("split_bvalid_early0", bus.bvalid, 0);
        tick();
        tick();
        check("split_bvalid_early2", bus.bvalid, 0);
        bus.awaddr = 32'h20; bus.awvalid = 1'b1;
        check("split_awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        check("split_bvalid", bus.bvalid, 1);
        check("split_bresp", bus.bresp, 0);
        tick();
        do_read(32'h20, rd, resp);
        check("split_rdata", rd, 32'h11223344);

        // Byte strobes, then an all-zero strobe
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, resp);
        check("strb_bresp", resp, 0);
        do_read(32'h20, rd, resp);
        check("strb_rdata", rd, 32'h11BB33DD);
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000, resp);
        check("strb0_bresp", resp, 0);
        do_read(32'h20, rd, resp);
        check("strb0_rdata", rd, 32'h11BB33DD);

        // Write and read backpressure
        bus.bready = 1'b0;
        bus.awaddr = 32'h30; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", bus.bvalid, 1);
            check("bp_bresp", bus.bresp, 0);
            check("bp_awready", bus.awready, 0);
            check("bp_wready", bus.wready, 0);
            tick();
        end
        bus.bready = 1'b1;
        tick();
        check("bp_bvalid_clr", bus.bvalid, 0);
        check("bp_awready_back", bus.awready, 1);
        bus.rready = 1'b0;
        bus.araddr = 32'h30; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_rvalid", bus.rvalid, 1);
            check("bp_rdata", bus.rdata, 32'hCAFEF00D);
            check("bp_rresp", bus.rresp, 0);
            check("bp_arready", bus.arready, 0);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        check("bp_rvalid_clr", bus.rvalid, 0);
        check("bp_arready_back", bus.arready, 1);

        // Read captured on the same edge as a write to that word sees old data
        do_write(32'h50, 32'h12345678, 4'hF, resp);
        bus.awaddr = 32'h50; bus.wdata = 32'hFFFF0000; bus.wstrb = 4'hF;
        bus.araddr = 32'h50;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("rw_bvalid", bus.bvalid, 1);
        check("rw_rdata_old", bus.rdata, 32'h12345678);
        tick();
        do_read(32'h50, rd, resp);
        check("rw_rdata_new", rd, 32'hFFFF0000);

        // Reset after AW accepted but before W
        do_write(32'h40, 32'h55555555, 4'hF, resp);
        do_read(32'h40, rd, resp);
        bus.awaddr = 32'h40; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("mid_aw_held", bus.awready, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wready", bus.wready, 0);
        check("mid_rst_arready", bus.arready, 0);
        check("mid_rst_rdata", bus.rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_awready", bus.awready, 1);
        bus.wdata = 32'h99999999; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick();
        check("mid_no_stale_b", bus.bvalid, 0);
        bus.awaddr = 32'h44; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("mid_fresh_bvalid", bus.bvalid, 1);
        tick();
        do_read(32'h40, rd, resp);
        check("mid_old_word", rd, 32'h55555555);
        do_read(32'h44, rd, resp);
        check("mid_new_word", rd, 32'h99999999);

        // Address 0x1000 is one past the end of a 1024-word RAM
        do_write(32'h0, 32'h01020304, 4'hF, resp);
        do_write(32'h1000, 32'hA5A5A5A5, 4'hF, resp);
`ifdef AXIL_MEM_RANGE_CHECK_EN
        check("oor_bresp", resp, 2'b10);
        do_read(32'h1000, rd, resp);
        check("oor_rdata", rd, 0);
        check("oor_rresp", resp, 2'b10);
        do_read(32'h0, rd, resp);
        check("oor_word0", rd, 32'h01020304);
`else
        check("alias_bresp", resp, 0);
        do_read(32'h1000, rd, resp);
        check("alias_rdata", rd, 32'hA5A5A5A5);
        check("alias_rresp", resp, 0);
        do_read(32'h0, rd, resp);
        check("alias_word0", rd, 32'hA5A5A5A5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_chip_mem_slave.md
Name: axil_chip_mem_slave

Overview:
AXI4-Lite slave memory that is the core of the chip. It sits behind the AXI-Lite master and the passthrough monitor point, and services single-beat writes and reads into an internal word-addressed RAM. It returns OKAY responses, or SLVERR for out-of-range accesses when range checking is compiled in.

Parameters:
ADDR_W, 32, byte-address width of AW/AR channels
DATA_W, 32, data width; fixed at 32, WSTRB is 4 bits
DEPTH, 1024, number of 32-bit words; power of two, at least 2

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axil_awaddr  in  ADDR_W  write byte address
s_axil_awprot  in  3  ignored
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i]
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response; 00 OKAY, 10 SLVERR
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_W  read byte address
s_axil_arprot  in  3  ignored
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready

Behaviour:
- Reset (aresetn low, asynchronous):
  - bvalid, rvalid, all internal held flags go to 0; bresp, rresp, rdata go to 0.
  - All ready outputs are 0 while aresetn is low.
  - RAM contents are not cleared.
- Word index is addr[log2(DEPTH)+1:2]; addr[1:0] ignored.
- Write path: registers aw_held and w_held hold the captured address and data.
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are accepted independently, in either order, on valid&&ready.
  - In the first cycle where both are available (held, or handshaking that cycle), the RAM is updated with per-byte WSTRB at the next edge.
  - At that same edge bvalid=1 with bresp, and aw_held/w_held clear.
  - AW and W in the same cycle: bvalid rises on the next edge (latency 1).
  - wstrb=0: RAM unchanged, bresp OKAY.
  - bvalid holds, bresp stable, until bready; a new write is not accepted until then.
  - bvalid&&bready clears bvalid; a new AW/W may be accepted in the following cycle.
- Read path:
  - arready = !rvalid.
  - On arvalid&&arready, rdata is registered from the RAM and rvalid=1 at the next edge (latency 1).
  - rdata and rresp are held stable until rready; rvalid&&rready clears rvalid.
- Read and write channels are fully independent.
- Read captured on the same edge as a write to the same word returns the old data.
- Reset mid-transaction abandons it: a pending write is not performed and no response is issued.
- No state machine beyond the held and valid flags.

Optional Feature:
Macro AXIL_MEM_RANGE_CHECK_EN.
- Defined: an address >= DEPTH*4 (any nonzero upper bit) is out of range.
  - Out-of-range write: RAM unchanged, bresp=10.
  - Out-of-range read: rdata=0, rresp=10.
  - Handshake timing is identical to in-range accesses.
- Undefined: upper address bits are ignored, addresses alias modulo DEPTH*4, and all responses are OKAY (00).

Test Plan:
- Basic write/read:
  - Stimulus: AW=0x10 and W=0xDEADBEEF (wstrb F) in the same cycle, bready=1; then AR=0x10, rready=1.
  - Response: bvalid exactly 1 cycle after the handshake, bresp 00; rvalid 1 cycle after AR, rdata 0xDEADBEEF, rresp 00.
- Split write:
  - Stimulus: W=0x11223344 presented 3 cycles before AW=0x20.
  - Response: wready drops after W is accepted; bvalid 1 cycle after AW; readback 0x11223344.
- Byte strobes:
  - Stimulus: 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 0101.
  - Response: readback 0x11BB33DD.
- Backpressure:
  - Stimulus: hold bready=0 for 5 cycles after a write; hold rready=0 for 4 cycles after a read.
  - Response: bvalid and bresp stable throughout, awready/wready 0; rvalid, rdata, rresp stable, arready 0; both clear 1 cycle after ready.
- Reset mid-operation:
  - Stimulus: aresetn low after AW is accepted but before W.
  - Response: outputs 0 immediately; after release, a fresh write completes normally and the old partial write is never applied.
- Range check:
  - Stimulus: write and read address 0x1000 with DEPTH=1024.
  - Response with AXIL_MEM_RANGE_CHECK_EN: bresp 10, rresp 10, rdata 0, word 0 unchanged.
  - Response without it: write aliases to word 0, readback of 0x0 returns the written data.
